piso_serializer: RTL

- Parallel-in/serial-out stage. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock.
- Drives a serial bit (ser_dout) plus a per-bit enable strobe (ser_en). These feed directly into the data and enable inputs of downstream 1-bit enabled registers and bit-capture stages.
- Provides busy status and a one-cycle done pulse for the controlling logic.

---
 rtl/piso_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word on a valid/ready handshake
// and emits one bit per clock with an enable strobe. Define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_dout,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int unsigned TERM = WIDTH + 1;
`else
  localparam int unsigned TERM = WIDTH;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_dout;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
`ifdef PISO_PARITY_EN
  logic             r_parity;
`endif

  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_shifted;

  // The shift register always holds the not-yet-sent bits at the outgoing end.
  assign w_first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1]   : r_shift[0];
  assign w_load_shift = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
  assign w_shifted    = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}   : {1'b0, r_shift[WIDTH-1:1]};

  assign load_ready = (r_state == IDLE);
  assign ser_dout   = r_dout;
  assign ser_en     = r_en;
  assign busy       = r_busy;
  assign done       = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_shift  <= w_load_shift;
            r_dout   <= w_first_bit;
            r_en     <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= CW'(1);
            r_state  <= SHIFT;
`ifdef PISO_PARITY_EN
            r_parity <= ^load_data;
`endif
          end
        end
        SHIFT: begin
          if (r_cnt == CW'(TERM)) begin
            r_dout  <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
`ifdef PISO_PARITY_EN
          end else if (r_cnt == CW'(WIDTH)) begin
            r_dout <= r_parity;
            r_cnt  <= r_cnt + CW'(1);
`endif
          end else begin
            r_dout  <= w_next_bit;
            r_shift <= w_shifted;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
